// File: rtl/crossbar_output_scheduler.sv
// ----------------------------------------------------------------------------
// crossbar_output_scheduler
//
// Per-egress frame scheduler for the switch crossbar. Several source FIFOs
// hold whole frames for the same egress port. This block picks one source
// round-robin, pops that FIFO one byte per cycle while the MAC is ready,
// releases the grant at end of frame and then holds an inter-frame gap
// before the next grant.
//
// Parameters:
//   N_SRC            number of source ports (2..8)
//   IFG_CYCLES       idle cycles enforced between frames (1..255)
//   MAX_FRAME_BYTES  watchdog byte limit (only used with FRAME_WATCHDOG_EN)
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req        in   [N_SRC] source i holds at least one complete frame
//   eof        in   [N_SRC] head byte of FIFO i is the last of its frame
//   tx_ready   in   egress MAC accepts a byte this cycle
//   grant      out  [N_SRC] one-hot crossbar mux select, 0 when idle
//   grant_idx  out  [3] binary index of the granted source
//   rd_en      out  [N_SRC] one-hot pop strobe to the granted FIFO
//   tx_valid   out  byte on the crossbar data path is valid (pop + 1 cycle)
//   tx_last    out  with tx_valid, last byte of the frame
//   busy       out  scheduler is not IDLE
//   abort      out  one-cycle pulse when the watchdog truncates a frame
//
// Build option:
//   FRAME_WATCHDOG_EN  when defined, frames longer than MAX_FRAME_BYTES are
//                      cut: the MAC sees tx_last on the limit byte, abort
//                      pulses, and the rest of the frame is drained from the
//                      FIFO without tx_valid.
//
// State  | Meaning
// -------+--------------------------------------------------------------
// IDLE   | no grant; pick next requester round-robin
// ARM    | grant driven, one settle cycle for the mux, no pop
// XFER   | pop granted FIFO whenever tx_ready is high
// DRAIN  | (watchdog only) pop every cycle, discard bytes until eof
// GAP    | grant released, count down the inter-frame gap
// ----------------------------------------------------------------------------

module crossbar_output_scheduler #(
    parameter int N_SRC           = 4,
    parameter int IFG_CYCLES      = 12,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] eof,
    input  logic             tx_ready,
    output logic [N_SRC-1:0] grant,
    output logic [2:0]       grant_idx,
    output logic [N_SRC-1:0] rd_en,
    output logic             tx_valid,
    output logic             tx_last,
    output logic             busy,
    output logic             abort
);

    localparam int             IW       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [7:0]     GAP_LOAD = 8'(IFG_CYCLES - 1);
    localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

    if (N_SRC < 2 || N_SRC > 8 || IFG_CYCLES < 1 || IFG_CYCLES > 255 ||
        MAX_FRAME_BYTES < 1 || MAX_FRAME_BYTES > 2047) begin : g_param_check
        $error("crossbar_output_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        XFER  = 3'd2,
        GAP   = 3'd3
`ifdef FRAME_WATCHDOG_EN
        ,
        DRAIN = 3'd4
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       last;
    logic [2:0]       last_nxt;
    logic [N_SRC-1:0] grant_nxt;
    logic [2:0]       idx_nxt;
    logic [7:0]       gap_cnt;
    logic [7:0]       gap_nxt;
    logic             tx_valid_nxt;
    logic             tx_last_nxt;
    logic             eof_sel;
    logic             rr_found;
    logic [2:0]       rr_idx;

`ifdef FRAME_WATCHDOG_EN
    localparam logic [10:0] WD_LIMIT = 11'(MAX_FRAME_BYTES);
    logic [10:0] byte_cnt;
    logic [10:0] byte_cnt_nxt;
    logic [10:0] byte_cnt_inc;
    logic        abort_q;
    logic        abort_nxt;

    assign byte_cnt_inc = byte_cnt + 11'd1;
    assign abort        = abort_q;
`else
    assign abort = 1'b0;
`endif

    // eof of the granted source only; grant is one-hot so a reduction OR
    // selects it without a variable index.
    assign eof_sel = |(eof & grant);
    assign busy    = (state != IDLE);

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        int cand;
        cand     = 0;
        rr_found = 1'b0;
        rr_idx   = 3'd0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = (int'(last) + k) % N_SRC;
            if (!rr_found && req[cand[IW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = 3'(cand);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        idx_nxt      = grant_idx;
        last_nxt     = last;
        gap_nxt      = gap_cnt;
        tx_valid_nxt = 1'b0;
        tx_last_nxt  = 1'b0;
        rd_en        = '0;
`ifdef FRAME_WATCHDOG_EN
        byte_cnt_nxt = byte_cnt;
        abort_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt = ONE_HOT0 << rr_idx;
                    idx_nxt   = rr_idx;
                    last_nxt  = rr_idx;
                    state_nxt = ARM;
                end
            end
            ARM: begin
`ifdef FRAME_WATCHDOG_EN
                byte_cnt_nxt = '0;
`endif
                state_nxt = XFER;
            end
            XFER: begin
                if (tx_ready) begin
                    rd_en        = grant;
                    tx_valid_nxt = 1'b1;
`ifdef FRAME_WATCHDOG_EN
                    byte_cnt_nxt = byte_cnt_inc;
`endif
                    if (eof_sel) begin
                        tx_last_nxt = 1'b1;
                        grant_nxt   = '0;
                        gap_nxt     = GAP_LOAD;
                        state_nxt   = GAP;
                    end
`ifdef FRAME_WATCHDOG_EN
                    else if (byte_cnt_inc == WD_LIMIT) begin
                        // Close the frame at the MAC on this byte, then
                        // discard the remainder from the FIFO.
                        tx_last_nxt = 1'b1;
                        abort_nxt   = 1'b1;
                        state_nxt   = DRAIN;
                    end
`endif
                end
            end
`ifdef FRAME_WATCHDOG_EN
            DRAIN: begin
                rd_en = grant;
                if (eof_sel) begin
                    grant_nxt = '0;
                    gap_nxt   = GAP_LOAD;
                    state_nxt = GAP;
                end
            end
`endif
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - 8'd1;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= 3'(N_SRC - 1);
            grant     <= '0;
            grant_idx <= 3'd0;
            gap_cnt   <= 8'd0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
`ifdef FRAME_WATCHDOG_EN
            byte_cnt  <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            gap_cnt   <= gap_nxt;
            tx_valid  <= tx_valid_nxt;
            tx_last   <= tx_last_nxt;
`ifdef FRAME_WATCHDOG_EN
            byte_cnt  <= byte_cnt_nxt;
            abort_q   <= abort_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_crossbar_output_scheduler.sv
`timescale 1ns/1ps

module tb_crossbar_output_scheduler;

    localparam int N      = 4;
    localparam int IFG    = 12;
    localparam int WD_MAX = 16;
`ifdef FRAME_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] eof = '0;
    logic         tx_ready = 1'b0;
    logic [N-1:0] grant;
    logic [2:0]   grant_idx;
    logic [N-1:0] rd_en;
    logic         tx_valid;
    logic         tx_last;
    logic         busy;
    logic         abort;

    crossbar_output_scheduler #(
        .N_SRC(N), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(WD_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .eof(eof), .tx_ready(tx_ready),
        .grant(grant), .grant_idx(grant_idx), .rd_en(rd_en), .tx_valid(tx_valid),
        .tx_last(tx_last), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- source FIFO model + scoreboard ----------------
    typedef struct { int idx; int space; } gexp_t;

    int           cyc = 0;
    int           rem[N];
    int           flen[N];
    int           fleft[N];
    int           ld_len[N];
    int           ld_cnt[N];
    int           ld_seq = 0;
    int           ld_seen = 0;
    logic [N-1:0] pend = '0;
    bit           exp_q[$];
    gexp_t        g_q[$];
    bit           prev_valid = 0;
    bit           exp_abort = 0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] exp_rd;
    int           fb = 0;
    int           t_grant = 0, t_load = 0, t_pop = 0, t_txv = 0, t_gap = -100;
    bit           first_pop_pend = 0, first_txv_pend = 0;
    int           pops_tot = 0, txv_cnt = 0, last_cnt = 0, abort_cnt = 0;
    int           pops_src[N];
    int           s;
    bit           is_eof;
    bit           exp_last;
    gexp_t        g;

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; flen[i] = 0; fleft[i] = 0; ld_len[i] = 0; ld_cnt[i] = 0; pops_src[i] = 0;
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                rem[i] = 0; fleft[i] = 0;
            end
            pend = '0;
            exp_q.delete();
            g_q.delete();
            prev_valid = 0; exp_abort = 0; fb = 0; t_gap = -100;
            ld_seen = ld_seq;
            req = '0; eof = '0;
        end else begin
            // pops committed at the last rising edge advance the FIFO heads
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    rem[i]--;
                    if (rem[i] == 0 && fleft[i] > 0) begin
                        rem[i] = flen[i];
                        fleft[i]--;
                    end
                end
            end
            pend = '0;
            if (ld_seen != ld_seq) begin
                ld_seen = ld_seq;
                t_load = cyc;
                first_pop_pend = 1; first_txv_pend = 1;
                for (int i = 0; i < N; i++) begin
                    if (ld_cnt[i] > 0) begin
                        flen[i] = ld_len[i]; rem[i] = ld_len[i]; fleft[i] = ld_cnt[i] - 1;
                    end
                end
            end

            // output checks
            chk("tx_valid", 32'(tx_valid), 32'(prev_valid));
            exp_last = 0;
            if (prev_valid && exp_q.size() > 0) exp_last = exp_q.pop_front();
            chk("tx_last", 32'(tx_last), 32'(exp_last));
            if (tx_valid) begin
                txv_cnt++;
                if (tx_last) last_cnt++;
                if (first_txv_pend) begin t_txv = cyc; first_txv_pend = 0; end
            end
            chk("abort", 32'(abort), 32'(exp_abort));
            if (abort) abort_cnt++;

            if (grant != '0 && prev_grant == '0) begin
                if (g_q.size() == 0) begin
                    chk("grant_unexpected", 32'(grant), 32'(0));
                end else begin
                    g = g_q.pop_front();
                    chk("grant_idx", 32'(grant_idx), 32'(g.idx));
                    chk("grant", 32'(grant), 32'(1) << g.idx);
                    if (g.space > 0) chk("grant_space", 32'(cyc - t_grant), 32'(g.space));
                end
                t_grant = cyc;
                fb = 0;
            end else if (grant != '0) begin
                chk("grant_hold", 32'(grant), 32'(prev_grant));
            end
            if (grant != '0) chk("grant_onehot", 32'(grant), 32'(1) << grant_idx);

            if (cyc > t_gap && cyc <= t_gap + IFG) begin
                chk("gap_busy", 32'(busy), 32'(1));
                chk("gap_grant", 32'(grant), 32'(0));
            end
            if (cyc == t_gap + IFG + 1) chk("idle_busy", 32'(busy), 32'(0));

            exp_rd = '0;
            if (grant != '0 && cyc > t_grant)
                exp_rd = ((WD && fb >= WD_MAX) || tx_ready) ? grant : '0;
            chk("rd_en", 32'(rd_en), 32'(exp_rd));

            // record this cycle's pop and push the expected MAC view of it
            prev_valid = 0; exp_abort = 0;
            if (rd_en != '0) begin
                s = 0;
                for (int i = 0; i < N; i++) if (rd_en[i]) s = i;
                pend = rd_en;
                pops_tot++; pops_src[s]++; fb++;
                if (first_pop_pend) begin t_pop = cyc; first_pop_pend = 0; end
                is_eof = (rem[s] == 1);
                if (!WD || fb <= WD_MAX) begin
                    prev_valid = 1;
                    exp_q.push_back(is_eof || (WD && fb == WD_MAX));
                end
                if (WD && fb == WD_MAX && !is_eof) exp_abort = 1;
                if (is_eof) t_gap = cyc;
            end
            for (int i = 0; i < N; i++) begin
                req[i] = (rem[i] > 0);
                eof[i] = (rem[i] == 1);
            end
        end
        prev_grant = grant;
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [N-1:0] mask, input int len, input int cnt);
        for (int i = 0; i < N; i++) begin
            ld_cnt[i] = mask[i] ? cnt : 0;
            ld_len[i] = len;
        end
        ld_seq++;
    endtask

    task automatic push_g(input int idx, input int space);
        gexp_t e;
        e.idx = idx; e.space = space;
        g_q.push_back(e);
    endtask

    function automatic bit all_done();
        bit d;
        d = (ld_seen == ld_seq) && (pend == '0) && !busy && (grant == '0);
        for (int i = 0; i < N; i++) if (rem[i] != 0) d = 0;
        return d;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!all_done() && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(n < budget), 32'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;
    endtask

    int           sp_pops, sp_txv, sp_last, sp_abort, sp_src2, n;
    logic [3:0]   pat;

    initial begin
        tx_ready = 1;
        reset_n  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_grant_idx", 32'(grant_idx), 32'(0));
        chk("rst_rd_en", 32'(rd_en), 32'(0));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("rst_tx_last", 32'(tx_last), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_abort", 32'(abort), 32'(0));
        reset_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // single request, source 2, 64-byte frame
        sp_pops = pops_tot; sp_txv = txv_cnt; sp_last = last_cnt;
        push_g(2, 0);
        load(4'b0100, 64, 1);
        wait_done("single_done", 400);
        chk("single_t_grant", 32'(t_grant - t_load), 32'(1));
        chk("single_t_pop", 32'(t_pop - t_load), 32'(2));
        chk("single_t_txv", 32'(t_txv - t_load), 32'(3));
        chk("single_pops", 32'(pops_tot - sp_pops), 32'(64));
        chk("single_txv", 32'(txv_cnt - sp_txv), 32'(64));
        chk("single_last", 32'(last_cnt - sp_last), 32'(1));

        // fairness from reset: all four request, two 8-byte frames each
        do_reset();
        sp_pops = pops_tot; sp_last = last_cnt;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_g(i, (r == 0 && i == 0) ? 0 : 8 + IFG + 2);
        load(4'b1111, 8, 2);
        wait_done("fair_done", 600);
        chk("fair_pops", 32'(pops_tot - sp_pops), 32'(64));
        chk("fair_last", 32'(last_cnt - sp_last), 32'(8));
        chk("fair_q_empty", 32'(g_q.size()), 32'(0));

        // backpressure: tx_ready cycles 1,0,0,1 during the frame
        sp_pops = pops_tot; sp_txv = txv_cnt;
        pat = 4'b1001;
        push_g(1, 0);
        load(4'b0010, 16, 1);
        n = 0;
        @(posedge clk); #1;
        while (!all_done() && n < 300) begin
            tx_ready = pat[n % 4];
            @(posedge clk); #1;
            n++;
        end
        chk("bp_done", 32'(n < 300), 32'(1));
        tx_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_pops", 32'(pops_tot - sp_pops), 32'(16));
        chk("bp_txv", 32'(txv_cnt - sp_txv), 32'(16));

        // reset at byte 30 of a 64-byte frame; last winner was 1
        push_g(2, 0);
        sp_src2 = pops_src[2];
        load(4'b0100, 64, 1);
        n = 0;
        while (pops_src[2] - sp_src2 < 30 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_reach30", 32'(n < 200), 32'(1));
        #1 reset_n = 0;
        #1;
        chk("mid_grant", 32'(grant), 32'(0));
        chk("mid_grant_idx", 32'(grant_idx), 32'(0));
        chk("mid_rd_en", 32'(rd_en), 32'(0));
        chk("mid_tx_valid", 32'(tx_valid), 32'(0));
        chk("mid_tx_last", 32'(tx_last), 32'(0));
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_abort", 32'(abort), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) push_g(i, (i == 0) ? 0 : 4 + IFG + 2);
        load(4'b1111, 4, 1);
        wait_done("post_rst_done", 300);
        chk("post_rst_q_empty", 32'(g_q.size()), 32'(0));

        // long frame: truncated with the watchdog, passes whole without it
        sp_pops = pops_tot; sp_txv = txv_cnt; sp_last = last_cnt; sp_abort = abort_cnt;
        push_g(0, 0);
        load(4'b0001, 40, 1);
        wait_done("long_done", 400);
        chk("long_pops", 32'(pops_tot - sp_pops), 32'(40));
        chk("long_txv", 32'(txv_cnt - sp_txv), WD ? 32'(WD_MAX) : 32'(40));
        chk("long_last", 32'(last_cnt - sp_last), 32'(1));
        chk("long_abort", 32'(abort_cnt - sp_abort), WD ? 32'(1) : 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t want <200000", $time);
        $fatal(1);
    end

endmodule

// File: doc/crossbar_output_scheduler.md
# crossbar_output_scheduler

Per-output-port frame scheduler for the switch crossbar. Several source ports queue whole frames in their crossbar FIFOs for the same egress port; this block picks one source with round-robin fairness, then pops that FIFO byte by byte while the egress transmitter is ready. It releases the grant at end of frame and enforces an inter-frame gap before the next grant. One instance sits in front of each egress MAC.

## Interface
- `N_SRC`, default 4: number of source ports (requesters), range 2..8.
- `IFG_CYCLES`, default 12: idle cycles enforced between frames, range 1..255.
- `MAX_FRAME_BYTES`, default 1522: watchdog byte limit, used only with the macro below.
- `clk`  in  1: clock; all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  N_SRC: bit i high while source FIFO i holds at least one complete frame for this port.
- `eof`  in  N_SRC: bit i high when the byte currently at the head of FIFO i is the last byte of its frame.
- `tx_ready`  in  1: egress MAC accepts a byte this cycle.
- `grant`  out  N_SRC: one-hot mux select to the crossbar; all zeros when no source is granted.
- `grant_idx`  out  3: binary index of the granted source.
- `rd_en`  out  N_SRC: one-hot pop strobe to the granted FIFO.
- `tx_valid`  out  1: the byte on the crossbar data path is valid. Asserted one cycle after a pop (FIFO read latency is 1).
- `tx_last`  out  1: asserted with `tx_valid` on the last byte of the frame.
- `busy`  out  1: the state is not IDLE.
- `abort`  out  1: one-cycle pulse when the watchdog truncates a frame.

## Operation
- State register: IDLE, ARM, XFER, DRAIN, GAP. Round-robin pointer `last`, width 3.
- IDLE: if `req != 0`, select the first set bit searching from `last+1` upward, with wrap-around modulo N_SRC. Register `grant` and `grant_idx`, set `last` to the selected index, go to ARM. Otherwise stay in IDLE.
- ARM: lasts one cycle. `grant` is held and there is no pop, which gives the mux one cycle to settle. Go to XFER.
- XFER: `rd_en[grant_idx] = tx_ready` (combinational). A pop with `eof[grant_idx]` high ends the frame and moves to GAP.
- GAP: `grant` clears on entry. A counter loads `IFG_CYCLES-1`, decrements each cycle, and moves to IDLE at 0.
- DRAIN (macro only): `rd_en[grant_idx]` is held high regardless of `tx_ready`, and `tx_valid` stays low. A pop with `eof` high moves to GAP.
- `req` changes during ARM, XFER, DRAIN or GAP are ignored. `eof` and `req` bits of non-granted sources are ignored.
- `tx_ready` low in XFER: no pop, and state, counters and grant are held.
- The `rd_en` and `grant` bits are always a subset of one another. `rd_en` is never asserted outside XFER and DRAIN.

## Timing
- All outputs are 0 on reset: `grant`, `grant_idx`, `rd_en`, `tx_valid`, `tx_last`, `busy`, `abort`. State goes to IDLE and `last` is set to N_SRC-1, so source 0 wins first.
- Reset asserted mid-frame forces IDLE immediately and asynchronously. The partially read frame is not recovered; the FIFOs are reset by the same signal.
- Request-to-first-pop latency is 2 cycles (IDLE→ARM→XFER) when `tx_ready` is high.
- First `tx_valid` occurs 3 cycles after `req` is sampled.
- `tx_valid`/`tx_last` are the pop/`eof` registered by one cycle. `tx_valid` is suppressed for DRAIN pops.
- Frame-to-frame minimum: the last pop, then IFG_CYCLES GAP cycles, then 1 IDLE cycle, then ARM, then the next pop.
- Back-to-back requests from the same source still rotate: after source i, all other requesting sources are served before i again.

## Configuration
- `FRAME_WATCHDOG_EN` defined:
  - An 11-bit byte counter clears on entry to XFER and increments on each XFER pop.
  - If the counter reaches MAX_FRAME_BYTES with no `eof` pop, `abort` pulses for 1 cycle and the state moves to DRAIN.
  - `tx_last` is asserted on that final XFER byte so the MAC closes the frame.
- `FRAME_WATCHDOG_EN` undefined: no counter and no DRAIN state. `abort` is tied to 0 and frames of any length pass through.

## Test plan
- Single request: reset, then `req=4'b0100`, `tx_ready=1`, 64-byte frame. Expect `grant=4'b0100` and `grant_idx=2`, first `rd_en[2]` 2 cycles later, 64 pops, `tx_last` on byte 64, then 12 GAP cycles with `busy=1`, then IDLE.
- Fairness: `req=4'b1111` held, 8-byte frames. Expect grant order 0,1,2,3,0, with each grant gap equal to 8 pops + 12 + 2 cycles.
- Backpressure: during XFER, `tx_ready` toggles 1,0,0,1. Expect `rd_en` to mirror `tx_ready`, `tx_valid` to follow one cycle later, and grant to be held.
- Reset mid-frame: `reset_n` low at byte 30 of a 64-byte frame. Expect all outputs 0 in the same cycle, and source 0 granted first after release.
- Watchdog (macro on, MAX_FRAME_BYTES=16): 40-byte frame. Expect 16 `tx_valid`, `tx_last` on byte 16, an `abort` pulse, and 24 DRAIN pops with `tx_valid=0`, then GAP.
- Watchdog off: the same 40-byte frame passes fully, with `abort` never asserted.
